// File: rtl/regfile_bypass_sb_if.sv
// Register-file bus: two read ports with scoreboard bits, two write ports
// (A = ALU writeback, B = memory writeback), the issue strobe and the busy count.
//   master : drives addresses, write ports and issue; receives read data, busy bits, count
//   slave  : the register file side of the same signals
interface regfile_bypass_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic              RSbusy_o;
    logic              RTbusy_o;
    logic              WAen_i;
    logic [ADDR_W-1:0] WAaddr_i;
    logic [DATA_W-1:0] WAdata_i;
    logic              WBen_i;
    logic [ADDR_W-1:0] WBaddr_i;
    logic [DATA_W-1:0] WBdata_i;
    logic              Issue_i;
    logic [ADDR_W-1:0] IssueAddr_i;
    logic [ADDR_W:0]   BusyCount_o;

    modport master (
        output RSaddr_i, RTaddr_i,
        output WAen_i, WAaddr_i, WAdata_i,
        output WBen_i, WBaddr_i, WBdata_i,
        output Issue_i, IssueAddr_i,
        input  RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, BusyCount_o
    );

    modport slave (
        input  RSaddr_i, RTaddr_i,
        input  WAen_i, WAaddr_i, WAdata_i,
        input  WBen_i, WBaddr_i, WBdata_i,
        input  Issue_i, IssueAddr_i,
        output RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, BusyCount_o
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-read / two-write register file with write-through bypass, optional
// hardwired-zero register 0 and a per-register busy scoreboard.
// Ports:
//   clk_i    : clock, all state updates on the rising edge
//   rst_n_i  : asynchronous active-low reset (clears registers, busy bits, count)
//   bus      : slave side of regfile_bypass_sb_if (read ports S/T with busy bits,
//              write ports A/B, issue strobe, registered BusyCount_o)
// Write port A has priority over B when both target the same register.
module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    regfile_bypass_sb_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;

    // Effective enables: register 0 swallows writes and issues when hardwired.
    logic wa_ok;
    logic wb_ok;
    logic wb_keep;
    logic iss_ok;
    logic set_inc;
    logic clr_a;
    logic clr_b;

    logic rs_hit_a, rs_hit_b, rt_hit_a, rt_hit_b;
    logic rs_iss, rt_iss;

    always_comb begin
        wa_ok   = bus.WAen_i  && !(ZERO_REG && (bus.WAaddr_i == '0));
        wb_ok   = bus.WBen_i  && !(ZERO_REG && (bus.WBaddr_i == '0));
        iss_ok  = bus.Issue_i && !(ZERO_REG && (bus.IssueAddr_i == '0));
        wb_keep = wb_ok && !(wa_ok && (bus.WBaddr_i == bus.WAaddr_i));
    end

    // Busy count is updated incrementally from the (at most three) bits that can
    // change this cycle. A write and an issue to the same register leave it busy,
    // so that write does not count as a clear.
    always_comb begin
        set_inc = iss_ok && !busy_q[bus.IssueAddr_i];
        clr_a   = wa_ok && busy_q[bus.WAaddr_i]
                  && !(iss_ok && (bus.IssueAddr_i == bus.WAaddr_i));
        clr_b   = wb_keep && busy_q[bus.WBaddr_i]
                  && !(iss_ok && (bus.IssueAddr_i == bus.WBaddr_i));
        count_d = count_q + (ADDR_W+1)'(set_inc)
                          - (ADDR_W+1)'(clr_a)
                          - (ADDR_W+1)'(clr_b);
    end

    always_comb begin
        busy_d = busy_q;
        if (wa_ok) begin
            busy_d[bus.WAaddr_i] = 1'b0;
        end
        if (wb_ok) begin
            busy_d[bus.WBaddr_i] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[bus.IssueAddr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_keep) begin
                regs_q[bus.WBaddr_i] <= bus.WBdata_i;
            end
            if (wa_ok) begin
                regs_q[bus.WAaddr_i] <= bus.WAdata_i;
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Read side: combinational from addresses, stored state and write inputs.
    always_comb begin
        rs_hit_a = wa_ok && (bus.WAaddr_i == bus.RSaddr_i);
        rs_hit_b = wb_ok && (bus.WBaddr_i == bus.RSaddr_i);
        rt_hit_a = wa_ok && (bus.WAaddr_i == bus.RTaddr_i);
        rt_hit_b = wb_ok && (bus.WBaddr_i == bus.RTaddr_i);
        rs_iss   = iss_ok && (bus.IssueAddr_i == bus.RSaddr_i);
        rt_iss   = iss_ok && (bus.IssueAddr_i == bus.RTaddr_i);
    end

    always_comb begin
        bus.RSdata_o = '0;
        bus.RTdata_o = '0;
        bus.RSbusy_o = 1'b0;
        bus.RTbusy_o = 1'b0;
        // Gating with rst_n_i keeps in-flight write data off the outputs during reset.
        if (rst_n_i) begin
            if (ZERO_REG && (bus.RSaddr_i == '0)) begin
                bus.RSdata_o = '0;
            end else if (BYPASS && rs_hit_a) begin
                bus.RSdata_o = bus.WAdata_i;
            end else if (BYPASS && rs_hit_b) begin
                bus.RSdata_o = bus.WBdata_i;
            end else begin
                bus.RSdata_o = regs_q[bus.RSaddr_i];
            end

            if (ZERO_REG && (bus.RTaddr_i == '0)) begin
                bus.RTdata_o = '0;
            end else if (BYPASS && rt_hit_a) begin
                bus.RTdata_o = bus.WAdata_i;
            end else if (BYPASS && rt_hit_b) begin
                bus.RTdata_o = bus.WBdata_i;
            end else begin
                bus.RTdata_o = regs_q[bus.RTaddr_i];
            end

            // A write arriving this cycle resolves the hazard early, unless a new
            // producer is issued to the same register in the same cycle.
            bus.RSbusy_o = busy_q[bus.RSaddr_i]
                           && !(BYPASS && (rs_hit_a || rs_hit_b) && !rs_iss);
            bus.RTbusy_o = busy_q[bus.RTaddr_i]
                           && !(BYPASS && (rt_hit_a || rt_hit_b) && !rt_iss);
        end
    end

    assign bus.BusyCount_o = count_q;

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised two-read/two-write register file with write-through bypass, optional hardwired-zero register and a per-register busy scoreboard. It replaces the single-write register file in the CPU datapath: read ports feed the ID stage, write port A takes the ALU writeback, write port B takes the memory writeback, and the scoreboard tells hazard logic which source registers still have a write in flight.

## Interface
- DATA_W, 32, data width of every register
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 always reads 0, ignores writes, never busy
- BYPASS, 1, 1: same-cycle write data forwarded to read ports; 0: reads return stored value only

- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- RSaddr_i  in  ADDR_W  read port S address
- RTaddr_i  in  ADDR_W  read port T address
- RSdata_o  out  DATA_W  read port S data
- RTdata_o  out  DATA_W  read port T data
- RSbusy_o  out  1  scoreboard bit for RSaddr_i
- RTbusy_o  out  1  scoreboard bit for RTaddr_i
- WAen_i  in  1  write port A enable (ALU writeback)
- WAaddr_i  in  ADDR_W  write port A address
- WAdata_i  in  DATA_W  write port A data
- WBen_i  in  1  write port B enable (memory writeback)
- WBaddr_i  in  ADDR_W  write port B address
- WBdata_i  in  DATA_W  write port B data
- Issue_i  in  1  mark IssueAddr_i busy (instruction with destination issued)
- IssueAddr_i  in  ADDR_W  destination register being issued
- BusyCount_o  out  ADDR_W+1  number of registers currently busy

## Operation
- State: 2**ADDR_W registers of DATA_W bits, 2**ADDR_W busy bits, BusyCount register.
- Reset (rst_n_i low, asynchronous): all registers 0, all busy bits 0, BusyCount 0; holds while low. Outputs with reset asserted: RSdata_o/RTdata_o = 0, RSbusy_o/RTbusy_o = 0, BusyCount_o = 0 (bypass inputs ignored during reset).
- Write: on rising edge, WAen_i writes WAdata_i to WAaddr_i; WBen_i writes WBdata_i to WBaddr_i. Both enabled, same address: port A wins, port B dropped. Different addresses: both written.
- ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 even with bypass; busy bit 0 never set.
- Read (combinational): BYPASS=1 and WAen_i with WAaddr_i == read address -> WAdata_i; else WBen_i with matching WBaddr_i -> WBdata_i; else stored value. BYPASS=0 -> stored value.
- Scoreboard: any enabled write to address clears its busy bit at the edge; Issue_i sets busy bit of IssueAddr_i. Issue and write to same address in same cycle -> bit ends 1 (new producer).
- RSbusy_o/RTbusy_o: stored busy bit, masked to 0 when BYPASS=1 and an enabled write to that address is present this cycle and Issue_i is not targeting it... (mask applies to write only; Issue this cycle does not affect output until next cycle).
- BusyCount: next = current + (bits newly set) − (bits newly cleared); setting an already-busy bit or clearing an idle bit changes nothing. Range 0..2**ADDR_W, never wraps.

## Timing
- Read data and busy outputs: zero latency, combinational from addresses, stored state and write inputs.
- Write visible in stored state one cycle after edge; with BYPASS=1 visible same cycle.
- Busy set by Issue_i visible from the cycle after the issuing edge.
- BusyCount_o registered; reflects state after the last edge.
- Reset release synchronous to nothing: first write accepted on first rising edge with rst_n_i high.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, issue r7, assert rst_n_i low between edges -> immediately RSdata_o(r5)=0, RSbusy_o(r7)=0, BusyCount_o=0.
- Dual write conflict: WA r3=0x11, WB r3=0x22 same edge -> r3 reads 0x11; WA r4=0x33, WB r6=0x44 -> both stored.
- Bypass: RSaddr_i=9, WBen_i r9=0xCAFE same cycle -> RSdata_o=0xCAFE before edge; add WAen_i r9=0xBEEF -> RSdata_o=0xBEEF. BYPASS=0 build -> old value until next cycle.
- Zero register: WA r0=0xFFFFFFFF, Issue r0 -> r0 reads 0, RSbusy_o=0, BusyCount_o unchanged.
- Scoreboard: issue r1, r2 on two edges -> BusyCount_o 1 then 2; issue r1 again -> stays 2; write r1 with issue r2 same edge -> 1, r2 busy; write r1 with issue r1 same edge -> r1 still busy.
- Full count: issue all 31 nonzero registers (ZERO_REG=1) -> BusyCount_o=31; write all back -> 0, no underflow on extra writes.
